tipi_mailbox_sync: RTL
======================

Name: tipi_mailbox_sync

Overview:
- Clock-synchronous, parametrised successor to the TIPI CPLD/FPGA glue.
- Bridges the TI-99/4A expansion bus to the Raspberry Pi serial shift-register link.
- Provides NUM_CH byte mailboxes in each direction (TI->RPi and RPi->TI), plus the CRU device-enable and RPi-reset bits.
- All asynchronous TI and RPi strobes are synchronised into clk; per-channel sticky "new data" flags tell the Pi which TI mailboxes were written.

Parameters:
- NUM_CH, 2, mailbox pairs; 1..8.
- SYNC_STAGES, 2, flip-flop stages on ti_we, ti_cruclk and rpi_shclk; >=2.
- REG_TOP, 16'h5FFF, highest mailbox address; mailboxes sit on odd addresses descending from here.
- SEL_W, $clog2(2*NUM_CH), localparam; width of rpi_regsel.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-high reset.
- ti_a  in  [0:15]  TI address; bit 0 is the MSB.
- ti_data  in  [0:7]  TI write data; bit 0 is the MSB.
- ti_memen  in  1  memory enable, active low.
- ti_we  in  1  write strobe, active low.
- ti_dbin  in  1  read, active high.
- ti_cruclk  in  1  CRU clock, active low.
- cru_base  in  4  CRU nibble n, selecting base 0x1n00.
- rpi_regsel  in  SEL_W  selects the serial register.
- rpi_sdata_in  in  1  serial data from the Pi.
- rpi_le  in  1  latch/load qualifier, sampled at the shclk edge.
- rpi_shclk  in  1  serial clock from the Pi.
- rpi_sdata_out  out  1  serial data to the Pi.
- dsr_d  out  [0:7]  registered read data to the bus transceiver.
- tipi_dbus_oe  out  1  transceiver enable, active low.
- rpi_reset  out  1  active-low reset request to the Pi services.
- dev_en  out  1  CRU bit 0 state.
- tx_new  out  NUM_CH  sticky flags: TI wrote mailbox k.

Behaviour:
- Address map for mailbox k:
  - TI->RPi mailbox k (write-only from TI) is at REG_TOP-2k.
  - RPi->TI mailbox k (read-only from TI) is at REG_TOP-2*NUM_CH-2k.
  - Default map: TX 5FFF, 5FFD; RX 5FFB, 5FF9.
- Reset values: tx_q=0, rx_q=0, all shifters=0, tx_new=0, dev_en=0, pireset_q=0 (so rpi_reset=1), rpi_sdata_out=0, dsr_d=0. All synchroniser chains reset to idle-high.
- Strobe detection: each of ti_we, ti_cruclk and rpi_shclk passes through SYNC_STAGES flops. A one-cycle event pulse is generated from the last two stages: falling edge for we and cruclk, rising edge for shclk. ti_a, ti_data and the rpi_* qualifiers are sampled raw in the event cycle; they are stable throughout the strobe.
- TI write: on a we-fall event with ~ti_memen, dev_en=1 and ti_a equal to a TX address k:
  - tx_q[k] <= ti_data;
  - tx_new[k] <= 1.
  - Writes to any other address, or with dev_en=0, are ignored.
- CRU: on a cruclk-fall event with ti_a[0:3]==4'h1 and ti_a[4:7]==cru_base:
  - ti_a[8:14]==0 -> dev_en <= ti_a[15];
  - ti_a[8:14]==1 -> pireset_q <= ti_a[15].
  - rpi_reset = ~pireset_q.
- Serial link, on a shclk-rise event with s = rpi_regsel:
  - s<NUM_CH (RX channel s):
    - le=1 -> rx_q[s] <= rx_sh[s];
    - le=0 -> rx_sh[s] <= {rx_sh[s][6:0], sdata_in}.
  - NUM_CH<=s<2*NUM_CH (TX channel j=s-NUM_CH):
    - le=1 -> tx_sh[j] <= tx_q[j] and tx_new[j] <= 0;
    - le=0 -> rpi_sdata_out <= tx_sh[j][7], then tx_sh[j] <= tx_sh[j]<<1 with 0 shifted in.
  - s>=2*NUM_CH: no effect.
  - The Pi therefore needs 1 load edge followed by 8 shift edges per byte, MSB first.
- Simultaneous events in the same clk cycle:
  - TI write to tx_q[j] and Pi load of channel j: the load captures the old tx_q value; tx_new[j] ends at 1 (set wins over clear).
  - TI read of rx_q[k] while the Pi latches it: dsr_d shows the old value this cycle and the new value next cycle.
- Read path, registered with 1-clk latency from ti_a:
  - ti_a==RX addr k -> dsr_d <= rx_q[k];
  - ti_a in 4000..(lowest mailbox address - 1) -> dsr_d <= 0 (ROM data is supplied by a separate block via an external mux);
  - otherwise dsr_d <= 0.
- tipi_dbus_oe is combinational: 0 iff dev_en & ~ti_memen & ti_dbin & ti_a is an RX address. It is never asserted for TX addresses.
- Reset asserted mid-transfer: all state clears immediately. A partial serial byte is discarded and the Pi must restart with a load.

Decomposition:
- Package tipi_pkg:
  - REG_TOP default;
  - CRU_BIT_EN=7'h00 and CRU_BIT_PIRESET=7'h01;
  - function tx_addr(k) and function rx_addr(k).
- One sub-module, tipi_edge_sync (SYNC_STAGES, IDLE, RISE): synchroniser chain plus single-cycle edge pulse. Instantiated three times.

Test Plan:
1. Reset, then CRU write a=1100 bit0=1 with cru_base=1 -> dev_en=1. Then write a=1102 with a[15]=1 -> rpi_reset=0.
2. dev_en=1, TI writes 0xA5 to 5FFF -> tx_new[0]=1. Pi: regsel=2, one le edge, then 8 shifts -> serial stream 1,0,1,0,0,1,0,1 and tx_new[0]=0.
3. Pi shifts 0x3C into regsel=1 then asserts le; TI read of 5FF9 -> tipi_dbus_oe=0 and dsr_d=0x3C one clk after the address is stable.
4. dev_en=0: TI write 0x11 to 5FFD and read 5FFB -> tx_q[1] unchanged, oe stays 1.
5. TI write 0x77 to 5FFF in the same clk as the Pi load on regsel=2 -> shifted-out byte is the old value, tx_new[0]=1.
6. rst pulsed after 4 of 8 shift edges -> all outputs at their reset values; a fresh load and 8 shifts deliver the full byte correctly.

Source files
------------

// File: rtl/tipi_pkg.sv
// Shared constants and mailbox address helpers for the TIPI mailbox bridge.
package tipi_pkg;

  localparam logic [15:0] REG_TOP_DEFAULT = 16'h5FFF;
  localparam logic [6:0]  CRU_BIT_EN      = 7'h00;
  localparam logic [6:0]  CRU_BIT_PIRESET = 7'h01;

  // TI->RPi mailbox k: odd addresses descending from the top of the window.
  function automatic logic [15:0] tx_addr(input logic [15:0] top, input int k);
    return top - 16'(2 * k);
  endfunction

  // RPi->TI mailbox k sits directly below the block of TX mailboxes.
  function automatic logic [15:0] rx_addr(input logic [15:0] top, input int num_ch, input int k);
    return top - 16'(2 * num_ch) - 16'(2 * k);
  endfunction

endpackage

// File: rtl/tipi_edge_sync.sv
// Synchroniser chain for an asynchronous strobe with a single-cycle edge pulse
// derived from the last two stages.
module tipi_edge_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit IDLE        = 1'b1,
  parameter bit RISE        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   w_new;
  logic                   w_old;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= {SYNC_STAGES{IDLE}};
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
    end
  end

  assign w_new = r_chain[SYNC_STAGES-2];
  assign w_old = r_chain[SYNC_STAGES-1];

  generate
    if (RISE) begin : g_rise
      assign o_pulse = w_new & ~w_old;
    end else begin : g_fall
      assign o_pulse = ~w_new & w_old;
    end
  endgenerate

endmodule

// File: rtl/tipi_mailbox_sync.sv
// TI-99/4A expansion bus to Raspberry Pi serial link bridge: NUM_CH byte
// mailboxes per direction, CRU enable/reset bits, all strobes synchronised to clk.
module tipi_mailbox_sync
  import tipi_pkg::*;
#(
  parameter int          NUM_CH      = 2,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] REG_TOP     = REG_TOP_DEFAULT,
  localparam int         SEL_W       = $clog2(2 * NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:15]       ti_a,
  input  logic [0:7]        ti_data,
  input  logic              ti_memen,
  input  logic              ti_we,
  input  logic              ti_dbin,
  input  logic              ti_cruclk,
  input  logic [3:0]        cru_base,
  input  logic [SEL_W-1:0]  rpi_regsel,
  input  logic              rpi_sdata_in,
  input  logic              rpi_le,
  input  logic              rpi_shclk,
  output logic              rpi_sdata_out,
  output logic [0:7]        dsr_d,
  output logic              tipi_dbus_oe,
  output logic              rpi_reset,
  output logic              dev_en,
  output logic [NUM_CH-1:0] tx_new
);

  logic w_we_ev;
  logic w_cru_ev;
  logic w_sh_ev;

  tipi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b1), .RISE(1'b0)) u_we_sync (
    .clk(clk), .rst(rst), .i_async(ti_we), .o_pulse(w_we_ev)
  );

  tipi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b1), .RISE(1'b0)) u_cru_sync (
    .clk(clk), .rst(rst), .i_async(ti_cruclk), .o_pulse(w_cru_ev)
  );

  tipi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b1), .RISE(1'b1)) u_sh_sync (
    .clk(clk), .rst(rst), .i_async(rpi_shclk), .o_pulse(w_sh_ev)
  );

  logic              r_dev_en;
  logic              r_pireset;
  logic              r_sdata_out;
  logic [7:0]        r_dsr;
  logic [7:0]        r_tx_q  [NUM_CH];
  logic [7:0]        r_tx_sh [NUM_CH];
  logic [7:0]        r_rx_q  [NUM_CH];
  logic [7:0]        r_rx_sh [NUM_CH];
  logic              r_tx_new [NUM_CH];

  logic              w_wr_ok;
  logic              w_cru_hit;
  logic              w_rx_any;
  logic              w_sdo_next;
  logic [7:0]        w_rd_data;
  logic [NUM_CH-1:0] w_tx_hit;
  logic [NUM_CH-1:0] w_rx_hit;
  logic [NUM_CH-1:0] w_tx_wr;
  logic [NUM_CH-1:0] w_tx_sel;
  logic [NUM_CH-1:0] w_rx_sel;

  assign w_wr_ok = w_we_ev & ~ti_memen & r_dev_en;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam logic [SEL_W-1:0] RX_SEL = SEL_W'(gi);
      localparam logic [SEL_W-1:0] TX_SEL = SEL_W'(NUM_CH + gi);

      assign w_tx_hit[gi] = (ti_a == tx_addr(REG_TOP, gi));
      assign w_rx_hit[gi] = (ti_a == rx_addr(REG_TOP, NUM_CH, gi));
      assign w_tx_wr[gi]  = w_wr_ok & w_tx_hit[gi];
      assign w_tx_sel[gi] = w_sh_ev & (rpi_regsel == TX_SEL);
      assign w_rx_sel[gi] = w_sh_ev & (rpi_regsel == RX_SEL);
      assign tx_new[gi]   = r_tx_new[gi];

      // A TI write and a Pi load in the same cycle: load sees the old byte, set beats clear.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_tx_q[gi]   <= 8'h00;
          r_tx_sh[gi]  <= 8'h00;
          r_rx_q[gi]   <= 8'h00;
          r_rx_sh[gi]  <= 8'h00;
          r_tx_new[gi] <= 1'b0;
        end else begin
          if (w_tx_wr[gi]) begin
            r_tx_q[gi] <= ti_data;
          end
          if (w_tx_wr[gi]) begin
            r_tx_new[gi] <= 1'b1;
          end else if (w_tx_sel[gi] && rpi_le) begin
            r_tx_new[gi] <= 1'b0;
          end
          if (w_tx_sel[gi]) begin
            r_tx_sh[gi] <= rpi_le ? r_tx_q[gi] : {r_tx_sh[gi][6:0], 1'b0};
          end
          if (w_rx_sel[gi]) begin
            if (rpi_le) begin
              r_rx_q[gi] <= r_rx_sh[gi];
            end else begin
              r_rx_sh[gi] <= {r_rx_sh[gi][6:0], rpi_sdata_in};
            end
          end
        end
      end
    end
  endgenerate

  // Non-mailbox addresses (including the ROM window) read as zero here.
  always_comb begin
    w_sdo_next = r_sdata_out;
    w_rd_data  = 8'h00;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_tx_sel[k] && !rpi_le) begin
        w_sdo_next = r_tx_sh[k][7];
      end
      if (w_rx_hit[k]) begin
        w_rd_data = r_rx_q[k];
      end
    end
  end

  assign w_rx_any  = |w_rx_hit;
  assign w_cru_hit = w_cru_ev & (ti_a[0:3] == 4'h1) & (ti_a[4:7] == cru_base);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dev_en    <= 1'b0;
      r_pireset   <= 1'b0;
      r_sdata_out <= 1'b0;
      r_dsr       <= 8'h00;
    end else begin
      r_sdata_out <= w_sdo_next;
      r_dsr       <= w_rd_data;
      if (w_cru_hit && (ti_a[8:14] == CRU_BIT_EN)) begin
        r_dev_en <= ti_a[15];
      end
      if (w_cru_hit && (ti_a[8:14] == CRU_BIT_PIRESET)) begin
        r_pireset <= ti_a[15];
      end
    end
  end

  assign rpi_sdata_out = r_sdata_out;
  assign dsr_d         = r_dsr;
  assign dev_en        = r_dev_en;
  assign rpi_reset     = ~r_pireset;
  assign tipi_dbus_oe  = ~(r_dev_en & ~ti_memen & ti_dbin & w_rx_any);

endmodule
